// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and helpers for the cacheline arbiter and its picker.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  typedef enum logic {
    REQ_IC,
    REQ_DC
  } req_id_t;

  localparam int LINE_BITS_DEF = 256;

  // Clear the byte-offset bits so the adapter always sees a line address.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int offset_bits);
    logic [31:0] mask;
    mask = (32'(1) << offset_bits) - 32'(1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of the I-cache, D-cache and adapter-facing signals around the arbiter.
// slave  : arbiter view (serves the caches, drives the adapter)
// master : environment view (caches and adapter)
interface cacheline_arbiter_if
  import cache_arb_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF
) ();

  logic                 ic_read;
  logic [31:0]          ic_addr;
  logic [LINE_BITS-1:0] ic_rdata;
  logic                 ic_resp;

  logic                 dc_read;
  logic                 dc_write;
  logic [31:0]          dc_addr;
  logic [LINE_BITS-1:0] dc_wdata;
  logic [LINE_BITS-1:0] dc_rdata;
  logic                 dc_resp;

  logic [31:0]          dfp_addr;
  logic                 dfp_read;
  logic                 dfp_write;
  logic [LINE_BITS-1:0] dfp_wdata;
  logic [LINE_BITS-1:0] dfp_rdata;
  logic                 dfp_resp;

  modport slave (
    input  ic_read, ic_addr,
    output ic_rdata, ic_resp,
    input  dc_read, dc_write, dc_addr, dc_wdata,
    output dc_rdata, dc_resp,
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp
  );

  modport master (
    output ic_read, ic_addr,
    input  ic_rdata, ic_resp,
    output dc_read, dc_write, dc_addr, dc_wdata,
    input  dc_rdata, dc_resp,
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp
  );

endinterface

// File: rtl/cacheline_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin picker. A lone requester always wins;
// under contention the one that did not win last time is chosen.
module rr_arbiter2
  import cache_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  // Pick a winner; req[0] is the I-cache, req[1] the D-cache.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_IC;
    if (req == 2'b11) begin
      gnt_id = (last_grant == REQ_IC) ? REQ_DC : REQ_IC;
    end else if (req[1]) begin
      gnt_id = REQ_DC;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline adapter between the I-cache and D-cache. One whole-line
// transaction is latched at grant and held on dfp_* until dfp_resp.
//
// state | meaning
// IDLE  | sample requests, grant and latch the winner's operands
// BUSY  | latched request driven to the adapter, waiting for dfp_resp
// DONE  | turnaround cycle; requests ignored, dfp_read/dfp_write low
module cacheline_arbiter
  import cache_arb_pkg::*;
#(
  parameter int LINE_BITS   = LINE_BITS_DEF,
  parameter int OFFSET_BITS = 5
) (
  input logic               clk,
  input logic               rst,
  cacheline_arbiter_if.slave bus
);

  arb_state_t           state;
  arb_state_t           state_nxt;
  req_id_t              owner;
  req_id_t              last_grant;
  logic                 lat_read;
  logic                 lat_write;
  logic [31:0]          lat_addr;
  logic [LINE_BITS-1:0] lat_wdata;

  logic [1:0]           req;
  logic                 gnt_valid;
  req_id_t              gnt_id;
  logic                 grant;
  logic                 finish;

  assign req = {bus.dc_read | bus.dc_write, bus.ic_read};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Next-state decode plus grant/finish strobes for the latch registers.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          grant     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.dfp_resp) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winner at grant; drop the op strobes once the adapter responds.
  // A D-cache request with both read and write set is issued as a write so a
  // dirty line goes out before any fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= REQ_IC;
      last_grant <= REQ_IC;
      lat_read   <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (grant) begin
      owner      <= gnt_id;
      last_grant <= gnt_id;
      if (gnt_id == REQ_IC) begin
        lat_read  <= 1'b1;
        lat_write <= 1'b0;
        lat_addr  <= line_align(bus.ic_addr, OFFSET_BITS);
        lat_wdata <= '0;
      end else begin
        lat_read  <= ~bus.dc_write;
        lat_write <= bus.dc_write;
        lat_addr  <= line_align(bus.dc_addr, OFFSET_BITS);
        lat_wdata <= bus.dc_wdata;
      end
    end else if (finish) begin
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
    end
  end

  assign bus.dfp_read  = lat_read;
  assign bus.dfp_write = lat_write;
  assign bus.dfp_addr  = lat_addr;
  assign bus.dfp_wdata = lat_wdata;

  assign bus.ic_rdata = bus.dfp_rdata;
  assign bus.dc_rdata = bus.dfp_rdata;
  assign bus.ic_resp  = bus.dfp_resp & (state == BUSY) & (owner == REQ_IC);
  assign bus.dc_resp  = bus.dfp_resp & (state == BUSY) & (owner == REQ_DC);

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: single reads/writes, contention order,
// operand capture at grant, read+write encoding and mid-transaction reset.
module tb_cacheline_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  localparam logic [255:0] DATA_A = {4{64'hAAAA_AAAA_AAAA_AAAA}};
  localparam logic [255:0] DATA_R = {4{64'h5A5A_5A5A_5A5A_5A5A}};
  localparam logic [255:0] DATA_W = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] DATA_X = {4{64'hFEDC_BA98_7654_3210}};

  cacheline_arbiter_if bus ();

  cacheline_arbiter dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.ic_read   = 1'b0;
    bus.ic_addr   = '0;
    bus.dc_read   = 1'b0;
    bus.dc_write  = 1'b0;
    bus.dc_addr   = '0;
    bus.dc_wdata  = '0;
    bus.dfp_rdata = DATA_R;
    bus.dfp_resp  = 1'b0;

    // reset state
    #2;
    chk("rst_dfp_read",  256'(bus.dfp_read),  256'(0));
    chk("rst_dfp_write", 256'(bus.dfp_write), 256'(0));
    chk("rst_dfp_addr",  256'(bus.dfp_addr),  256'(0));
    chk("rst_dfp_wdata", bus.dfp_wdata, 256'(0));
    chk("rst_ic_resp",   256'(bus.ic_resp),   256'(0));
    chk("rst_dc_resp",   256'(bus.dc_resp),   256'(0));
    chk("rst_ic_rdata",  bus.ic_rdata, DATA_R);
    chk("rst_dc_rdata",  bus.dc_rdata, DATA_R);
    step();
    step();
    rst_n = 1'b1;
    step();

    // single I-cache read
    bus.ic_read = 1'b1;
    bus.ic_addr = 32'h0000_1234;
    step();
    chk("ic1_read",  256'(bus.dfp_read),  256'(1));
    chk("ic1_write", 256'(bus.dfp_write), 256'(0));
    chk("ic1_addr",  256'(bus.dfp_addr),  256'(32'h0000_1220));
    step();
    chk("ic1_read_hold", 256'(bus.dfp_read), 256'(1));
    bus.dfp_rdata = DATA_A;
    bus.dfp_resp  = 1'b1;
    #1;
    chk("ic1_resp",    256'(bus.ic_resp), 256'(1));
    chk("ic1_rdata",   bus.ic_rdata, DATA_A);
    chk("ic1_dc_resp", 256'(bus.dc_resp), 256'(0));
    step();
    bus.dfp_resp = 1'b0;
    bus.ic_read  = 1'b0;
    #1;
    chk("ic1_read_drop", 256'(bus.dfp_read), 256'(0));
    chk("ic1_resp_drop", 256'(bus.ic_resp),  256'(0));
    step();

    // single D-cache writeback
    bus.dc_write = 1'b1;
    bus.dc_addr  = 32'h8000_0040;
    bus.dc_wdata = DATA_W;
    step();
    chk("dcw_write", 256'(bus.dfp_write), 256'(1));
    chk("dcw_read",  256'(bus.dfp_read),  256'(0));
    chk("dcw_addr",  256'(bus.dfp_addr),  256'(32'h8000_0040));
    chk("dcw_wdata", bus.dfp_wdata, DATA_W);
    step();
    chk("dcw_write_hold", 256'(bus.dfp_write), 256'(1));
    chk("dcw_addr_hold",  256'(bus.dfp_addr),  256'(32'h8000_0040));
    bus.dfp_resp = 1'b1;
    #1;
    chk("dcw_resp",    256'(bus.dc_resp), 256'(1));
    chk("dcw_ic_resp", 256'(bus.ic_resp), 256'(0));
    step();
    bus.dfp_resp = 1'b0;
    bus.dc_write = 1'b0;
    #1;
    chk("dcw_resp_drop",  256'(bus.dc_resp),   256'(0));
    chk("dcw_write_drop", 256'(bus.dfp_write), 256'(0));
    step();

    // contention right after reset: DC, IC, DC
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.ic_read = 1'b1;
    bus.ic_addr = 32'h0000_2004;
    bus.dc_read = 1'b1;
    bus.dc_addr = 32'h0000_3018;
    step();
    chk("rr1_read", 256'(bus.dfp_read), 256'(1));
    chk("rr1_addr", 256'(bus.dfp_addr), 256'(32'h0000_3000));
    bus.ic_addr = 32'h0000_4444;
    step();
    chk("rr1_addr_hold", 256'(bus.dfp_addr), 256'(32'h0000_3000));
    bus.dfp_resp = 1'b1;
    #1;
    chk("rr1_dc_resp", 256'(bus.dc_resp), 256'(1));
    chk("rr1_ic_resp", 256'(bus.ic_resp), 256'(0));
    step();
    bus.dfp_resp = 1'b0;
    #1;
    chk("rr1_gap1", 256'(bus.dfp_read), 256'(0));
    step();
    chk("rr1_gap2", 256'(bus.dfp_read), 256'(0));
    step();
    chk("rr2_read", 256'(bus.dfp_read), 256'(1));
    chk("rr2_addr", 256'(bus.dfp_addr), 256'(32'h0000_4440));
    bus.dfp_resp = 1'b1;
    #1;
    chk("rr2_ic_resp", 256'(bus.ic_resp), 256'(1));
    chk("rr2_dc_resp", 256'(bus.dc_resp), 256'(0));
    step();
    bus.dfp_resp = 1'b0;
    bus.ic_read  = 1'b0;
    #1;
    chk("rr2_gap1", 256'(bus.dfp_read), 256'(0));
    step();
    chk("rr2_gap2", 256'(bus.dfp_read), 256'(0));
    step();
    chk("rr3_read", 256'(bus.dfp_read), 256'(1));
    chk("rr3_addr", 256'(bus.dfp_addr), 256'(32'h0000_3000));
    bus.dfp_resp = 1'b1;
    #1;
    chk("rr3_dc_resp", 256'(bus.dc_resp), 256'(1));
    step();
    bus.dfp_resp = 1'b0;
    bus.dc_read  = 1'b0;
    step();

    // read and write together are issued as a write
    bus.dc_read  = 1'b1;
    bus.dc_write = 1'b1;
    bus.dc_addr  = 32'h0000_0117;
    bus.dc_wdata = DATA_X;
    step();
    chk("rw_write", 256'(bus.dfp_write), 256'(1));
    chk("rw_read",  256'(bus.dfp_read),  256'(0));
    chk("rw_addr",  256'(bus.dfp_addr),  256'(32'h0000_0100));
    chk("rw_wdata", bus.dfp_wdata, DATA_X);
    bus.dfp_resp = 1'b1;
    #1;
    chk("rw_resp", 256'(bus.dc_resp), 256'(1));
    step();
    bus.dfp_resp = 1'b0;
    bus.dc_read  = 1'b0;
    bus.dc_write = 1'b0;
    step();

    // reset in the middle of a transaction
    bus.ic_read = 1'b1;
    bus.ic_addr = 32'h0000_5008;
    step();
    chk("mr_read_pre", 256'(bus.dfp_read), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("mr_read_rst", 256'(bus.dfp_read), 256'(0));
    chk("mr_addr_rst", 256'(bus.dfp_addr), 256'(0));
    bus.dfp_resp = 1'b1;
    #1;
    chk("mr_ic_resp_rst", 256'(bus.ic_resp), 256'(0));
    chk("mr_dc_resp_rst", 256'(bus.dc_resp), 256'(0));
    bus.dfp_resp = 1'b0;
    rst_n = 1'b1;
    step();
    chk("mr_read_post", 256'(bus.dfp_read), 256'(1));
    chk("mr_addr_post", 256'(bus.dfp_addr), 256'(32'h0000_5000));
    chk("mr_no_stale",  256'(bus.ic_resp),  256'(0));
    bus.dfp_resp = 1'b1;
    #1;
    chk("mr_ic_resp", 256'(bus.ic_resp), 256'(1));
    step();
    bus.dfp_resp = 1'b0;
    bus.ic_read  = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
